mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and the
// load/store unit. At most one transaction is outstanding. The LSU normally wins
// arbitration, but fetch is forced through after STARVE_LIMIT consecutive losses.
// Grants and response strobes are combinational so that a response cycle can
// also grant the next request, giving one transaction every two cycles.
module mem_arbiter #(
    parameter int XLEN         = 32,  // matches riscv_pkg::XLEN
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    // instruction fetch port
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    // load/store port
    input  logic            lsu_req_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic            lsu_we_i,
    input  logic [3:0]      lsu_wstrb_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rvalid_o,
    // shared response data
    output logic [XLEN-1:0] rsp_rdata_o,
    // memory port
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_wstrb_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [SW-1:0]   r_starve;
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [3:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic            r_owner;      // 1 = LSU owns the outstanding transaction

    logic            w_resp;
    logic            w_window;
    logic            w_fetch_win;
    logic            w_lsu_win;

    // A response arrives only while waiting; the window opens in IDLE or on
    // that response, and is held shut while reset is asserted.
    assign w_resp      = (r_state == WAIT) && mem_rvalid_i;
    assign w_window    = rstn_i && ((r_state == IDLE) || w_resp);
    assign w_fetch_win = w_window && if_req_i && (!lsu_req_i || (r_starve == STARVE_MAX));
    assign w_lsu_win   = w_window && lsu_req_i && !w_fetch_win;

    assign if_gnt_o     = w_fetch_win;
    assign lsu_gnt_o    = w_lsu_win;
    assign if_rvalid_o  = w_resp && !r_owner;
    assign lsu_rvalid_o = w_resp && r_owner;
    assign rsp_rdata_o  = w_resp ? mem_rdata_i : {XLEN{1'b0}};

    assign mem_req_o   = (r_state == REQ);
    assign mem_addr_o  = r_addr;
    assign mem_we_o    = r_we;
    assign mem_wstrb_o = r_wstrb;
    assign mem_wdata_o = r_wdata;

    // Next-state decode for the IDLE / REQ / WAIT transaction sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_fetch_win || w_lsu_win) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = (w_fetch_win || w_lsu_win) ? REQ : IDLE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Count fetch losses against a waiting fetch, saturating at the limit
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_starve <= {SW{1'b0}};
        end else if (w_fetch_win) begin
            r_starve <= {SW{1'b0}};
        end else if (w_lsu_win && if_req_i && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // Capture the winner's request fields so they stay stable through REQ
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_addr  <= {XLEN{1'b0}};
            r_we    <= 1'b0;
            r_wstrb <= 4'b0000;
            r_wdata <= {XLEN{1'b0}};
            r_owner <= 1'b0;
        end else if (w_fetch_win) begin
            r_addr  <= if_addr_i;
            r_we    <= 1'b0;
            r_wstrb <= 4'b0000;
            r_wdata <= {XLEN{1'b0}};
            r_owner <= 1'b0;
        end else if (w_lsu_win) begin
            r_addr  <= lsu_addr_i;
            r_we    <= lsu_we_i;
            r_wstrb <= lsu_wstrb_i;
            r_wdata <= lsu_wdata_i;
            r_owner <= 1'b1;
        end else begin
            r_addr  <= r_addr;
            r_we    <= r_we;
            r_wstrb <= r_wstrb;
            r_wdata <= r_wdata;
            r_owner <= r_owner;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle table for single transactions plus scoreboard-driven
// sequences for starvation, a stalled store and reset during WAIT.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic        if_gnt_o, if_rvalid_o;
    logic        lsu_req_i = 1'b0;
    logic [31:0] lsu_addr_i = 32'h0;
    logic        lsu_we_i = 1'b0;
    logic [3:0]  lsu_wstrb_i = 4'h0;
    logic [31:0] lsu_wdata_i = 32'h0;
    logic        lsu_gnt_o, lsu_rvalid_o;
    logic [31:0] rsp_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
        .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i),
        .lsu_wstrb_i(lsu_wstrb_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .rsp_rdata_o(rsp_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic ifr; logic [31:0] ifa; logic lr; logic lwe; logic [31:0] la;
        logic mg; logic mv; logic [31:0] md;
        logic e_ig; logic e_lg; logic e_mr; logic e_ca; logic [31:0] e_ma;
        logic e_irv; logic e_lrv; logic [31:0] e_rd;
    } vec_t;
    vec_t tbl[13];

    typedef struct { logic lsu; logic st; } own_t;
    own_t q[$];

    logic exp_order[10];
    logic pend;
    int   gidx;
    int   nack;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk1({nm, "_if_gnt"}, if_gnt_o, 1'b0);
        chk1({nm, "_lsu_gnt"}, lsu_gnt_o, 1'b0);
        chk1({nm, "_if_rvalid"}, if_rvalid_o, 1'b0);
        chk1({nm, "_lsu_rvalid"}, lsu_rvalid_o, 1'b0);
        chk1({nm, "_mem_req"}, mem_req_o, 1'b0);
        chk1({nm, "_mem_we"}, mem_we_o, 1'b0);
        chk32({nm, "_mem_addr"}, mem_addr_o, 32'h0);
        chk32({nm, "_mem_wstrb"}, {28'h0, mem_wstrb_o}, 32'h0);
        chk32({nm, "_mem_wdata"}, mem_wdata_o, 32'h0);
        chk32({nm, "_rdata"}, rsp_rdata_o, 32'h0);
    endtask

    // Track grants in order and match every response strobe to its owner
    task automatic sb_observe();
        own_t o;
        if (if_gnt_o) q.push_back('{1'b0, 1'b0});
        if (lsu_gnt_o) q.push_back('{1'b1, lsu_we_i});
        if (if_rvalid_o || lsu_rvalid_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_rvalid: got if=%b lsu=%b expected no response",
                         if_rvalid_o, lsu_rvalid_o);
            end else begin
                o = q.pop_front();
                chk1("sb_lsu_rvalid", lsu_rvalid_o, o.lsu);
                chk1("sb_if_rvalid", if_rvalid_o, !o.lsu);
                if (!o.st) chk32("sb_rdata", rsp_rdata_o, mem_rdata_i);
            end
        end
    endtask

    initial begin
        // fields: ifr ifa lr lwe la mg mv md | e_ig e_lg e_mr e_ca e_ma e_irv e_lrv e_rd
        tbl[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h10,  1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,  1'b1, 1'b0, 32'h00500093};
        tbl[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h20,  1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h20,  1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h20,  1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h12345678};
        tbl[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'hCAFE0001};
        tbl[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5,        1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0};
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // ---- reset state, with requests and a stray response pending ----
        if_req_i = 1'b1; lsu_req_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
        step();
        step();
        chk_all_zero("reset");
        step();
        rstn_i = 1'b1;

        // ---- table: fetch path, stray response, stalled grant, handover ----
        for (int i = 0; i < 13; i++) begin
            if_req_i = tbl[i].ifr; if_addr_i = tbl[i].ifa;
            lsu_req_i = tbl[i].lr; lsu_we_i = tbl[i].lwe; lsu_addr_i = tbl[i].la;
            lsu_wstrb_i = 4'h0; lsu_wdata_i = 32'h0;
            mem_gnt_i = tbl[i].mg; mem_rvalid_i = tbl[i].mv; mem_rdata_i = tbl[i].md;
            #2;
            chk1($sformatf("tbl%0d_if_gnt", i), if_gnt_o, tbl[i].e_ig);
            chk1($sformatf("tbl%0d_lsu_gnt", i), lsu_gnt_o, tbl[i].e_lg);
            chk1($sformatf("tbl%0d_mem_req", i), mem_req_o, tbl[i].e_mr);
            if (tbl[i].e_ca) chk32($sformatf("tbl%0d_mem_addr", i), mem_addr_o, tbl[i].e_ma);
            chk1($sformatf("tbl%0d_if_rvalid", i), if_rvalid_o, tbl[i].e_irv);
            chk1($sformatf("tbl%0d_lsu_rvalid", i), lsu_rvalid_o, tbl[i].e_lrv);
            chk32($sformatf("tbl%0d_rdata", i), rsp_rdata_o, tbl[i].e_rd);
            step();
        end

        // ---- both requesting continuously: starvation-limited grant order ----
        gidx = 0; pend = 1'b0;
        for (int c = 0; c < 80 && (gidx < 10 || q.size() > 0); c++) begin
            if_req_i = (gidx < 10); lsu_req_i = (gidx < 10);
            if_addr_i = 32'h40; lsu_addr_i = 32'h80; lsu_we_i = 1'b0;
            mem_gnt_i = 1'b1; mem_rvalid_i = pend; mem_rdata_i = $urandom;
            #2;
            if (if_gnt_o || lsu_gnt_o) begin
                chk1("gnt_onehot", if_gnt_o && lsu_gnt_o, 1'b0);
                if (gidx < 10) chk1($sformatf("grant_order%0d", gidx), lsu_gnt_o, exp_order[gidx]);
                gidx++;
            end
            sb_observe();
            pend = mem_req_o && mem_gnt_i;
            step();
        end
        chk32("starve_grant_count", 32'(gidx), 32'd10);
        chk32("starve_sb_drain", 32'(q.size()), 32'd0);

        // ---- store with memory grant delayed three cycles ----
        pend = 1'b0; nack = 0;
        for (int k = 0; k < 10; k++) begin
            if_req_i = 1'b0; lsu_req_i = (k == 0); lsu_we_i = 1'b1;
            lsu_addr_i = 32'h100; lsu_wstrb_i = 4'b0011; lsu_wdata_i = 32'hDEADBEEF;
            mem_gnt_i = (k == 4); mem_rvalid_i = pend; mem_rdata_i = $urandom;
            #2;
            if (k == 0) chk1("store_gnt", lsu_gnt_o, 1'b1);
            if (k >= 1 && k <= 4) begin
                chk1($sformatf("store_req%0d", k), mem_req_o, 1'b1);
                chk32($sformatf("store_addr%0d", k), mem_addr_o, 32'h100);
                chk1($sformatf("store_we%0d", k), mem_we_o, 1'b1);
                chk32($sformatf("store_wstrb%0d", k), {28'h0, mem_wstrb_o}, 32'h3);
                chk32($sformatf("store_wdata%0d", k), mem_wdata_o, 32'hDEADBEEF);
            end
            if (lsu_rvalid_o) nack++;
            sb_observe();
            pend = mem_req_o && mem_gnt_i;
            step();
        end
        chk32("store_ack_once", 32'(nack), 32'd1);
        chk32("store_sb_drain", 32'(q.size()), 32'd0);

        // ---- saturate the starvation count, then reset during WAIT ----
        gidx = 0; pend = 1'b0; lsu_we_i = 1'b0;
        for (int k = 0; k < 20 && gidx < 4; k++) begin
            if_req_i = 1'b1; lsu_req_i = 1'b1;
            mem_gnt_i = 1'b1; mem_rvalid_i = pend; mem_rdata_i = $urandom;
            #2;
            if (if_gnt_o || lsu_gnt_o) begin
                chk1($sformatf("pre_rst_lsu_win%0d", gidx), lsu_gnt_o, 1'b1);
                gidx++;
            end
            sb_observe();
            pend = mem_req_o && mem_gnt_i;
            step();
        end
        chk32("pre_rst_grants", 32'(gidx), 32'd4);
        if_req_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
        step();
        mem_gnt_i = 1'b0;
        #2;
        chk1("wait_before_rst", mem_req_o, 1'b0);
        if_req_i = 1'b1; lsu_req_i = 1'b1;
        rstn_i = 1'b0;
        #1;
        chk_all_zero("in_reset");
        q.delete();
        step();
        rstn_i = 1'b1;
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hABCD0123;
        #2;
        chk_all_zero("post_rst");
        step();
        if_req_i = 1'b1; lsu_req_i = 1'b1; mem_rvalid_i = 1'b0;
        #2;
        chk1("post_rst_lsu_wins", lsu_gnt_o, 1'b1);
        chk1("post_rst_if_loses", if_gnt_o, 1'b0);
        step();
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
